// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer: opcode values, the sequencer
// state encoding and the shift-amount field width used by SLL/SRL.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RDREQ = 3'd1,
      S_CAPT  = 3'd2,
      S_EXEC  = 3'd3,
      S_WB    = 3'd4
   } state_e;

   // Shifts use only the low bits of the second operand.
   localparam int SHIFT_BITS = 5;

endpackage

// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the command handshake and the register-file port of the sequencer.
//   Command : cmd_valid, cmd_ready, cmd_op, cmd_rd, cmd_rs1, cmd_rs2
//   RF read : sel_o1, sel_o2, RD (strobe), Op1, Op2 (data, 1-cycle latency)
//   RF write: Ip1 (data), sel_i1 (select), WR (strobe), EN (enable)
// slave  = the sequencer side, master = the command source / register file.
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
   parameter int DW = 32,
   parameter int AW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [AW-1:0] cmd_rd;
   logic [AW-1:0] cmd_rs1;
   logic [AW-1:0] cmd_rs2;

   logic [AW-1:0] sel_o1;
   logic [AW-1:0] sel_o2;
   logic          RD;
   logic [DW-1:0] Op1;
   logic [DW-1:0] Op2;

   logic [DW-1:0] Ip1;
   logic [AW-1:0] sel_i1;
   logic          WR;
   logic          EN;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, Op1, Op2,
      input  cmd_ready, sel_o1, sel_o2, RD, Ip1, sel_i1, WR, EN
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, Op1, Op2,
      output cmd_ready, sel_o1, sel_o2, RD, Ip1, sel_i1, WR, EN
   );
endinterface

// File: rtl/seq_mul.sv
// ---------------------------------------------------------------------------
// seq_mul
// Sequential shift-add multiplier returning the low DW bits of the unsigned
// product. One multiplier bit is consumed per cycle, DW cycles in total.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load a/b (one-cycle pulse)
//   a, b      : multiplicand, multiplier
//   product   : result, valid while done is high and until the next start
//   done      : one-cycle pulse when product is complete
// ---------------------------------------------------------------------------
module seq_mul #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] product,
   output logic          done
);
   localparam int CW = $clog2(DW + 1);

   logic [DW-1:0] mcand;
   logic [DW-1:0] mplier;
   logic [CW-1:0] remaining;
   logic          active;

   // Bit 0 of the multiplier is folded into the load so the last bit lands
   // DW-1 cycles after start and done pulses on that same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         product   <= '0;
         mcand     <= '0;
         mplier    <= '0;
         remaining <= '0;
         active    <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            product   <= b[0] ? a : '0;
            mcand     <= a << 1;
            mplier    <= b >> 1;
            remaining <= CW'(DW - 1);
            active    <= 1'b1;
         end else if (active) begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand     <= mcand << 1;
            mplier    <= mplier >> 1;
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Accepts one ALU command at a time, reads both sources from an external
// register file, computes the result and writes it back.
// Sequence: IDLE -> RDREQ -> CAPT -> EXEC (1 cycle, or until the multiplier
// finishes for MUL) -> WB -> IDLE.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : command handshake + register-file port (slave modport);
//              the interface DW/AW must match this module's DW/AW
//   done     : one-cycle pulse in WB, alongside WR
//   busy     : high in every state except IDLE
//   flag_z/c : zero and carry/borrow of the last written result
// ---------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst,
   alu_sequencer_if.slave  bus,
   output logic            done,
   output logic            busy,
   output logic            flag_z,
   output logic            flag_c
);
   state_e        state;
   op_e           op_q;
   logic [AW-1:0] rd_q;
   logic [DW-1:0] op1_q;
   logic [DW-1:0] op2_q;

   logic          mul_start;
   logic          mul_done;
   logic [DW-1:0] mul_product;

   logic [DW:0]   alu_full;
   logic [DW-1:0] alu_res;
   logic          alu_carry;

   // The multiplier loads straight from the register-file data on the same
   // edge the operands are captured, so its 32 cycles coincide with EXEC.
   assign mul_start = (state == S_CAPT) && (op_q == OP_MUL);

   seq_mul #(.DW(DW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.Op1),
      .b       (bus.Op2),
      .product (mul_product),
      .done    (mul_done)
   );

   // Result and carry for the latched opcode; the top bit holds the ADD
   // carry-out or the SUB borrow and is zero for everything else.
   always_comb begin
      alu_full = '0;
      case (op_q)
         OP_ADD:  alu_full = {1'b0, op1_q} + {1'b0, op2_q};
         OP_SUB:  alu_full = {op1_q < op2_q, op1_q - op2_q};
         OP_AND:  alu_full = {1'b0, op1_q & op2_q};
         OP_OR:   alu_full = {1'b0, op1_q | op2_q};
         OP_XOR:  alu_full = {1'b0, op1_q ^ op2_q};
         OP_SLL:  alu_full = {1'b0, op1_q << op2_q[SHIFT_BITS-1:0]};
         OP_SRL:  alu_full = {1'b0, op1_q >> op2_q[SHIFT_BITS-1:0]};
         default: alu_full = {1'b0, mul_product};
      endcase
   end

   assign alu_res   = alu_full[DW-1:0];
   assign alu_carry = alu_full[DW];

   // Sequencer with every output registered; outputs change on the same edge
   // as the state transition that implies them. Reset aborts any operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         bus.cmd_ready <= 1'b0;
         bus.RD        <= 1'b0;
         bus.WR        <= 1'b0;
         bus.EN        <= 1'b0;
         bus.Ip1       <= '0;
         bus.sel_i1    <= '0;
         bus.sel_o1    <= '0;
         bus.sel_o2    <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
         flag_z        <= 1'b0;
         flag_c        <= 1'b0;
         op_q          <= OP_ADD;
         rd_q          <= '0;
         op1_q         <= '0;
         op2_q         <= '0;
      end else begin
         bus.EN <= 1'b1;
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  state         <= S_RDREQ;
                  bus.cmd_ready <= 1'b0;
                  busy          <= 1'b1;
                  bus.RD        <= 1'b1;
                  bus.sel_o1    <= bus.cmd_rs1;
                  bus.sel_o2    <= bus.cmd_rs2;
                  op_q          <= op_e'(bus.cmd_op);
                  rd_q          <= bus.cmd_rd;
               end else begin
                  bus.cmd_ready <= 1'b1;
               end
            end
            S_RDREQ: begin
               state <= S_CAPT;
            end
            S_CAPT: begin
               state  <= S_EXEC;
               bus.RD <= 1'b0;
               op1_q  <= bus.Op1;
               op2_q  <= bus.Op2;
            end
            S_EXEC: begin
               if (op_q != OP_MUL || mul_done) begin
                  state      <= S_WB;
                  bus.WR     <= 1'b1;
                  done       <= 1'b1;
                  bus.Ip1    <= alu_res;
                  bus.sel_i1 <= rd_q;
                  flag_z     <= (alu_res == '0);
                  flag_c     <= alu_carry;
               end
            end
            S_WB: begin
               state         <= S_IDLE;
               bus.WR        <= 1'b0;
               done          <= 1'b0;
               busy          <= 1'b0;
               bus.cmd_ready <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
- REQ-001: Parameter DW, default 32, datapath width; must equal the register-file word width.
- REQ-002: Parameter AW, default 4, register select width (16 registers).
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-low reset.
- REQ-005: cmd_valid  input  1  command offered; cmd_ready  output  1  block can accept.
- REQ-006: cmd_op  input  3  opcode; cmd_rd / cmd_rs1 / cmd_rs2  input  AW  destination and source selects.
- REQ-007: sel_o1 / sel_o2  output  AW  register-file read selects; RD  output  1  read strobe.
- REQ-008: Op1 / Op2  input  DW  register-file read data.
- REQ-009: Ip1  output  DW  write data; sel_i1  output  AW  write select; WR  output  1  write strobe.
- REQ-010: EN  output  1  register-file enable.
- REQ-011: done  output  1  one-cycle completion pulse; busy  output  1  high in every state except IDLE.
- REQ-012: flag_z / flag_c  output  1  zero and carry of the last written result.

Function
- REQ-013: States SHALL be IDLE, RDREQ, CAPT, EXEC, WB.
- REQ-014: cmd_ready SHALL be high only in IDLE; handshake is cmd_valid && cmd_ready; cmd_* fields are latched on that edge, and cmd_valid outside IDLE is ignored.
- REQ-015: IDLE -> RDREQ on handshake; RDREQ -> CAPT; CAPT -> EXEC; EXEC -> WB after 1 cycle (opcodes 0-6) or 32 cycles (MUL); WB -> IDLE.
- REQ-016: RD SHALL be high in RDREQ and CAPT, with sel_o1/sel_o2 driven from latched rs1/rs2; Op1/Op2 are captured at the end of CAPT (1-cycle register-file read latency).
- REQ-017: Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL by Op2[4:0], 110 SRL (logical) by Op2[4:0], 111 MUL (low DW bits of an unsigned product).
- REQ-018: flag_c SHALL be the ADD carry-out or the SUB borrow (Op1 < Op2 unsigned), and 0 for all other opcodes; flag_z = (result == 0); both update only in WB.
- REQ-019: In WB, WR=1, Ip1=result, and sel_i1=latched rd for exactly one cycle, and done=1 in the same cycle; outside WB, WR=0 and done=0.
- REQ-020: Latency from the handshake edge to the WB cycle SHALL be 4 cycles for opcodes 0-6 and 35 cycles for MUL; throughput is one command per latency+1 cycles.
- REQ-021: rd equal to rs1 or rs2 is legal; the source values are the ones captured in CAPT.
- REQ-022: EN SHALL be 1 whenever rst is deasserted.

Reset
- REQ-023: With rst low: state=IDLE, cmd_ready=0, RD=0, WR=0, EN=0, done=0, busy=0, Ip1=0, sel_i1=0, sel_o1=0, sel_o2=0, flag_z=0, flag_c=0, and the multiplier is cleared.
- REQ-024: Reset asserted mid-operation SHALL abort the operation immediately and asynchronously, with no write issued.
- REQ-025: cmd_ready SHALL rise on the first clock edge after rst deasserts.

Structure
- REQ-026: Package alu_seq_pkg SHALL hold the opcode constants and the state encoding.
- REQ-027: The 32-cycle shift-add multiplier SHALL be a sub-module seq_mul with start/done, instantiated once.

Verification
- REQ-028: Registers r0=0xABCDEF AB, r1=0x01234567; ADD rd=2, rs1=0, rs2=1 -> WR at handshake+4, Ip1=0xACF13512, sel_i1=2, flag_c=0, flag_z=0.
- REQ-029: SUB rd=3, rs1=1, rs2=1 -> Ip1=0, flag_z=1, flag_c=0; SUB rs1=1, rs2=0 -> flag_c=1.
- REQ-030: SLL rd=4, rs1=1, rs2=0 (shift 11) -> Ip1=0x1A2B3800.
- REQ-031: MUL with Op1=0x00001000, Op2=0x00000010 -> Ip1=0x00010000 at handshake+35; busy high throughout; cmd_ready low.
- REQ-032: cmd_valid held high back-to-back -> the second command is accepted only on the cycle after done; no WR overlap.
- REQ-033: rst pulsed low at cycle 10 of a MUL -> WR never asserts; IDLE on the next edge after release; a following ADD completes correctly.
